// File: rtl/sd_pkg.sv
// Shared constants, state encoding and small helpers for the SPI-mode SD command engine.
package sd_pkg;

   localparam int INIT_CLOCKS   = 80;
   localparam int NCR_MAX_BYTES = 8;
   localparam int TOKEN_BYTES   = 512;
   localparam int GAP_CLOCKS    = 8;

   // Down-counter load values; every timer ends on a terminal count of zero.
   localparam logic [6:0] TMR_INIT = 7'(INIT_CLOCKS - 1);
   localparam logic [6:0] TMR_SEND = 7'd47;
   localparam logic [6:0] TMR_NCR  = 7'(NCR_MAX_BYTES * 8 - 1);
   localparam logic [6:0] TMR_GAP  = 7'(GAP_CLOCKS - 1);
   localparam logic [9:0] TOK_INIT = 10'(TOKEN_BYTES - 1);

   localparam logic [5:0] CMD8_IDX  = 6'd8;
   localparam logic [5:0] CMD17_IDX = 6'd17;
   localparam logic [5:0] CMD58_IDX = 6'd58;

   localparam logic [7:0] DATA_TOKEN = 8'hFE;
   localparam logic [7:0] IDLE_BYTE  = 8'hFF;
   localparam logic [7:0] ERR_FLAGS  = 8'hFF;

   // Receive shifter lengths; R1 is 7 because its first bit is taken while hunting.
   localparam logic [5:0] LEN_R1   = 6'd7;
   localparam logic [5:0] LEN_BYTE = 6'd8;
   localparam logic [5:0] LEN_CRC  = 6'd16;
   localparam logic [5:0] LEN_WORD = 6'd32;

   typedef enum logic [3:0] {
      SD_POWERUP,
      SD_IDLE,
      SD_SEND,
      SD_WAIT_R1,
      SD_RECV_R1,
      SD_RECV_EXT,
      SD_WAIT_TOKEN,
      SD_RECV_DATA,
      SD_RECV_CRC,
      SD_GAP,
      SD_DONE
   } sd_state_e;

   // R3/R7 trailer follows only a clean R1 (no start-bit error, command accepted).
   function automatic logic has_trailer(input logic [5:0] idx, input logic [7:0] r1);
      return ((idx == CMD8_IDX) || (idx == CMD58_IDX)) && !r1[7] && !r1[2];
   endfunction

endpackage

// File: rtl/sd_shift_rx.sv
// MSB-first receive shifter with a down-counting bit counter; reused for every field read from D0.
module sd_shift_rx
   import sd_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load_i,
   input  logic [5:0]  len_i,
   input  logic        shift_i,
   input  logic        din_i,
   output logic        last_o,
   output logic [31:0] word_o
);

   logic [31:0] sr_q, sr_d;
   logic [5:0]  cnt_q, cnt_d;

   // Shift in one bit per enabled clock; a load re-arms the counter for the next field.
   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (shift_i) begin
         sr_d = {sr_q[30:0], din_i};
         if (cnt_q != 6'd0) begin
            cnt_d = cnt_q - 6'd1;
         end
      end
      if (load_i) begin
         cnt_d = len_i;
      end
   end

   // The word includes the bit being sampled so the FSM can act on it in the same edge.
   assign last_o = shift_i && (cnt_q == 6'd1);
   assign word_o = {sr_q[30:0], din_i};

   // Shifter and counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sd_cmd.sv
// SPI-mode SD command engine: one 48-bit frame out on D1, R1 plus optional trailer/read block in on D0.
//
// state      | meaning
// POWERUP    | card init clocks, CS=1, D1=1, start ignored
// IDLE       | waiting for start, CS=1, D1=1
// SEND       | 48 frame bits on D1, CS=0
// WAIT_R1    | hunting for the R1 start bit, bounded by the NCR timer
// RECV_R1    | remaining 7 bits of R1
// RECV_EXT   | 32-bit R3/R7 trailer
// WAIT_TOKEN | whole bytes until 0xFE, bounded by the token byte timer
// RECV_DATA  | 32 bits of read data
// RECV_CRC   | 16 CRC bits, discarded
// GAP        | trailing clocks with CS=1, D1=1
// DONE       | one-cycle done pulse
module sd_cmd
   import sd_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  cmd_number,
   input  logic [31:0] cmd_args,
   input  logic [7:0]  cmd_crc,
   input  logic        start,
   output logic        done,
   output logic [7:0]  response_flags,
   output logic [31:0] response_data,
   input  logic        D0,
   output logic        D1,
   output logic        CS
);

   sd_state_e   state_q, state_d;
   logic [6:0]  tmr_q, tmr_d;
   logic [9:0]  tok_q, tok_d;
   logic [47:0] tx_q, tx_d;
   logic [5:0]  idx_q, idx_d;
   logic        cs_q, cs_d;
   logic        d1_q, d1_d;
   logic        done_q, done_d;
   logic [7:0]  flags_q, flags_d;
   logic [31:0] data_q, data_d;

   logic        rx_load;
   logic [5:0]  rx_len;
   logic        rx_shift;
   logic        rx_last;
   logic [31:0] rx_word;

   sd_shift_rx u_rx (
      .clk     (clk),
      .reset   (reset),
      .load_i  (rx_load),
      .len_i   (rx_len),
      .shift_i (rx_shift),
      .din_i   (D0),
      .last_o  (rx_last),
      .word_o  (rx_word)
   );

   // Next-state, timer and output decode; all outputs are registered from here.
   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      tok_d    = tok_q;
      tx_d     = tx_q;
      idx_d    = idx_q;
      cs_d     = cs_q;
      d1_d     = d1_q;
      done_d   = 1'b0;
      flags_d  = flags_q;
      data_d   = data_q;
      rx_load  = 1'b0;
      rx_len   = LEN_BYTE;
      rx_shift = 1'b0;

      unique case (state_q)
         SD_POWERUP: begin
            if (tmr_q == 7'd0) begin
               state_d = SD_IDLE;
            end else begin
               tmr_d = tmr_q - 7'd1;
            end
         end

         SD_IDLE: begin
            if (start) begin
               // First bit goes straight to D1; the rest wait in the TX register.
               d1_d    = cmd_number[7];
               tx_d    = {cmd_number[6:0], cmd_args, cmd_crc, 1'b1};
               idx_d   = cmd_number[5:0];
               cs_d    = 1'b0;
               tmr_d   = TMR_SEND;
               state_d = SD_SEND;
            end
         end

         SD_SEND: begin
            if (tmr_q == 7'd0) begin
               d1_d    = 1'b1;
               tmr_d   = TMR_NCR;
               state_d = SD_WAIT_R1;
            end else begin
               d1_d  = tx_q[47];
               tx_d  = {tx_q[46:0], 1'b1};
               tmr_d = tmr_q - 7'd1;
            end
         end

         SD_WAIT_R1: begin
            if (!D0) begin
               // This zero is R1 bit 7; capture it and count the other seven.
               rx_shift = 1'b1;
               rx_load  = 1'b1;
               rx_len   = LEN_R1;
               state_d  = SD_RECV_R1;
            end else if (tmr_q == 7'd0) begin
               flags_d = ERR_FLAGS;
               data_d  = '0;
               cs_d    = 1'b1;
               tmr_d   = TMR_GAP;
               state_d = SD_GAP;
            end else begin
               tmr_d = tmr_q - 7'd1;
            end
         end

         SD_RECV_R1: begin
            rx_shift = 1'b1;
            if (rx_last) begin
               flags_d = rx_word[7:0];
               if (has_trailer(idx_q, rx_word[7:0])) begin
                  rx_load = 1'b1;
                  rx_len  = LEN_WORD;
                  state_d = SD_RECV_EXT;
               end else if ((idx_q == CMD17_IDX) && (rx_word[7:0] == 8'h00)) begin
                  rx_load = 1'b1;
                  rx_len  = LEN_BYTE;
                  tok_d   = TOK_INIT;
                  state_d = SD_WAIT_TOKEN;
               end else begin
                  data_d  = '0;
                  cs_d    = 1'b1;
                  tmr_d   = TMR_GAP;
                  state_d = SD_GAP;
               end
            end
         end

         SD_RECV_EXT: begin
            rx_shift = 1'b1;
            if (rx_last) begin
               data_d  = rx_word;
               cs_d    = 1'b1;
               tmr_d   = TMR_GAP;
               state_d = SD_GAP;
            end
         end

         SD_WAIT_TOKEN: begin
            rx_shift = 1'b1;
            if (rx_last) begin
               if (rx_word[7:0] == DATA_TOKEN) begin
                  rx_load = 1'b1;
                  rx_len  = LEN_WORD;
                  state_d = SD_RECV_DATA;
               end else if ((rx_word[7:0] == IDLE_BYTE) && (tok_q != 10'd0)) begin
                  rx_load = 1'b1;
                  rx_len  = LEN_BYTE;
                  tok_d   = tok_q - 10'd1;
               end else begin
                  // Error token, or the byte budget ran out on idle bytes.
                  flags_d = ERR_FLAGS;
                  data_d  = '0;
                  cs_d    = 1'b1;
                  tmr_d   = TMR_GAP;
                  state_d = SD_GAP;
               end
            end
         end

         SD_RECV_DATA: begin
            rx_shift = 1'b1;
            if (rx_last) begin
               data_d  = rx_word;
               rx_load = 1'b1;
               rx_len  = LEN_CRC;
               state_d = SD_RECV_CRC;
            end
         end

         SD_RECV_CRC: begin
            rx_shift = 1'b1;
            if (rx_last) begin
               cs_d    = 1'b1;
               tmr_d   = TMR_GAP;
               state_d = SD_GAP;
            end
         end

         SD_GAP: begin
            if (tmr_q == 7'd0) begin
               done_d  = 1'b1;
               state_d = SD_DONE;
            end else begin
               tmr_d = tmr_q - 7'd1;
            end
         end

         SD_DONE: begin
            state_d = SD_IDLE;
         end

         default: begin
            cs_d    = 1'b1;
            d1_d    = 1'b1;
            tmr_d   = TMR_INIT;
            state_d = SD_POWERUP;
         end
      endcase
   end

   // State, timers and registered outputs; reset aborts any transaction silently.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SD_POWERUP;
         tmr_q   <= TMR_INIT;
         tok_q   <= '0;
         tx_q    <= '1;
         idx_q   <= '0;
         cs_q    <= 1'b1;
         d1_q    <= 1'b1;
         done_q  <= 1'b0;
         flags_q <= ERR_FLAGS;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         tok_q   <= tok_d;
         tx_q    <= tx_d;
         idx_q   <= idx_d;
         cs_q    <= cs_d;
         d1_q    <= d1_d;
         done_q  <= done_d;
         flags_q <= flags_d;
         data_q  <= data_d;
      end
   end

   assign CS             = cs_q;
   assign D1             = d1_q;
   assign done           = done_q;
   assign response_flags = flags_q;
   assign response_data  = data_q;

endmodule

// File: tb/tb_sd_cmd.sv
// Directed bench for sd_cmd: a card model replays a planned D0 bit stream and a
// transaction-level model predicts bus activity, done timing and results.
module tb_sd_cmd;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  cmd_number;
   logic [31:0] cmd_args;
   logic [7:0]  cmd_crc;
   logic        start;
   logic        done;
   logic [7:0]  response_flags;
   logic [31:0] response_data;
   logic        D0;
   logic        D1;
   logic        CS;

   int n_pass = 0;
   int n_chk  = 0;

   // Card reply stream: rsp[k] is what D0 shows on the k-th sample after the frame.
   localparam int RSP_MAX = 8192;
   logic rsp [0:RSP_MAX-1];
   int   wp;

   logic [7:0]  prev_fl;
   logic [31:0] prev_dt;

   sd_cmd dut (
      .clk            (clk),
      .reset          (reset),
      .cmd_number     (cmd_number),
      .cmd_args       (cmd_args),
      .cmd_crc        (cmd_crc),
      .start          (start),
      .done           (done),
      .response_flags (response_flags),
      .response_data  (response_data),
      .D0             (D0),
      .D1             (D1),
      .CS             (CS)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic clr_rsp();
      for (int i = 0; i < RSP_MAX; i++) rsp[i] = 1'b1;
      wp = 0;
   endtask

   task automatic put_ones(input int n);
      wp = wp + n;
   endtask

   task automatic put_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         rsp[wp] = v[i];
         wp++;
      end
   endtask

   function automatic logic bit_at(input int i);
      return (i < RSP_MAX) ? rsp[i] : 1'b1;
   endfunction

   function automatic logic [31:0] get_bits(input int s, input int n);
      logic [31:0] r = '0;
      for (int i = 0; i < n; i++) r = {r[30:0], bit_at(s + i)};
      return r;
   endfunction

   // Transaction model: last = index of the last reply sample the engine consumes.
   function automatic void model(input logic [5:0] idx, output int last,
                                 output logic [7:0] fl, output logic [31:0] dt);
      int p = -1;
      int q;
      logic [7:0] b;
      bit found = 0;
      fl = 8'hFF; dt = '0; last = 63;
      for (int i = 0; i < 64; i++) if (bit_at(i) == 1'b0) begin p = i; break; end
      if (p < 0) return;
      fl = get_bits(p, 8)[7:0];
      last = p + 7;
      if ((idx == 6'd8 || idx == 6'd58) && !fl[7] && !fl[2]) begin
         dt = get_bits(p + 8, 32);
         last = p + 39;
      end else if (idx == 6'd17 && fl == 8'h00) begin
         q = p + 8;
         for (int k = 0; k < 512; k++) begin
            b = get_bits(q, 8)[7:0];
            q = q + 8;
            if (b == 8'hFF) continue;
            if (b == 8'hFE) begin
               dt = get_bits(q, 32);
               last = q + 47;
            end else begin
               fl = 8'hFF;
               last = q - 1;
            end
            found = 1;
            break;
         end
         if (!found) begin
            fl = 8'hFF;
            last = p + 7 + 4096;
         end
      end
   endfunction

   // Issue one command and check the bus on every cycle until the IDLE cycle after done.
   task automatic run_txn(input logic [7:0] num, input logic [31:0] args, input logic [7:0] crc,
                          input int exp_wait, input bit hold, input int lit_c,
                          input logic [7:0] lit_fl, input logic [31:0] lit_dt);
      logic [47:0] frame;
      logic [2:0]  exp_bus;
      logic [7:0]  efl;
      logic [31:0] edt;
      int          last;
      int          w = 0;
      frame = {num, args, crc};
      model(num[5:0], last, efl, edt);
      cmd_number = num; cmd_args = args; cmd_crc = crc;
      start = 1'b1;
      D0 = 1'b1;
      while (w < 200) begin
         @(negedge clk);
         w++;
         if (CS === 1'b0) break;
         chk("idle_bus", {CS, D1, done}, 3'b110);
         chk("idle_hold", {response_flags, response_data}, {prev_fl, prev_dt});
      end
      if (CS !== 1'b0) begin
         chk("accept_seen", CS, 1'b0);
         return;
      end
      if (exp_wait >= 0) chk("accept_wait", w, exp_wait);
      cmd_number = ~num; cmd_args = ~args; cmd_crc = ~crc;
      if (!hold) start = 1'b0;
      for (int c = 0; c <= 58 + last; c++) begin
         if (c <= 47)            exp_bus = {1'b0, frame[47 - c], 1'b0};
         else if (c <= 48 + last) exp_bus = 3'b010;
         else if (c == 57 + last) exp_bus = 3'b111;
         else                     exp_bus = 3'b110;
         chk($sformatf("bus@%0d", c), {CS, D1, done}, exp_bus);
         if (c == 57 + last) begin
            chk("flags", response_flags, efl);
            chk("data", response_data, edt);
         end
         if (c == 58 + last) chk("result_hold", {response_flags, response_data}, {efl, edt});
         if (lit_c >= 0 && c == lit_c) begin
            chk("lit_done", done, 1'b1);
            chk("lit_flags", response_flags, lit_fl);
            chk("lit_data", response_data, lit_dt);
         end
         D0 = (c >= 48) ? bit_at(c - 48) : 1'b1;
         if (c < 58 + last) @(negedge clk);
      end
      D0 = 1'b1;
      prev_fl = efl;
      prev_dt = edt;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; D0 = 1'b1;
      cmd_number = '0; cmd_args = '0; cmd_crc = '0;
      prev_fl = 8'hFF; prev_dt = '0;
      repeat (3) @(negedge clk);
      chk("rst_cs", CS, 1'b1);
      chk("rst_d1", D1, 1'b1);
      chk("rst_done", done, 1'b0);
      chk("rst_flags", response_flags, 8'hFF);
      chk("rst_data", response_data, 32'h0);
      reset = 1'b0;

      // Power-up window then CMD0, R1 0x01 after two idle bytes.
      clr_rsp(); put_ones(16); put_bits(32'h01, 8);
      run_txn(8'h40, 32'h0, 8'h95, 81, 0, 80, 8'h01, 32'h0);

      // CMD8 with R7 trailer.
      clr_rsp(); put_ones(8); put_bits(32'h01, 8); put_bits(32'h000001AA, 32);
      run_txn(8'h48, 32'h000001AA, 8'h87, 1, 0, 104, 8'h01, 32'h000001AA);

      // CMD8 rejected (illegal command bit): trailer ignored.
      clr_rsp(); put_ones(8); put_bits(32'h05, 8); put_bits(32'h000001AA, 32);
      run_txn(8'h48, 32'h000001AA, 8'h87, 1, 0, 72, 8'h05, 32'h0);

      // CMD17 single read with three idle bytes before the token.
      clr_rsp(); put_ones(8); put_bits(32'h00, 8);
      put_bits(32'hFFFFFFFE, 32); put_bits(32'hDEADBEEF, 32); put_bits(32'h1234, 16);
      run_txn(8'h51, 32'h00000010, 8'hFF, 1, 0, 152, 8'h00, 32'hDEADBEEF);

      // CMD17 with an error token.
      clr_rsp(); put_ones(8); put_bits(32'h00, 8); put_bits(32'hFFFFFF09, 32);
      run_txn(8'h51, 32'h00000010, 8'hFF, 1, 0, 104, 8'hFF, 32'h0);

      // No R1 at all.
      clr_rsp();
      run_txn(8'h40, 32'h0, 8'h95, 1, 0, 120, 8'hFF, 32'h0);

      // CMD17 where the token never arrives.
      clr_rsp(); put_bits(32'h00, 8);
      run_txn(8'h51, 32'h00000020, 8'hFF, 1, 0, 4160, 8'hFF, 32'h0);

      // CMD58 with start held through done, then an immediate CMD0.
      clr_rsp(); put_ones(8); put_bits(32'h00, 8); put_bits(32'hC0FF8000, 32);
      run_txn(8'h7A, 32'h0, 8'hFD, 1, 1, 104, 8'h00, 32'hC0FF8000);
      clr_rsp(); put_ones(16); put_bits(32'h01, 8);
      run_txn(8'h40, 32'h0, 8'h95, 1, 0, 80, 8'h01, 32'h0);

      // Reset in the middle of SEND.
      clr_rsp(); put_ones(16); put_bits(32'h01, 8);
      cmd_number = 8'h48; cmd_args = 32'h1AA; cmd_crc = 8'h87;
      start = 1'b1;
      for (int i = 0; i < 10 && CS !== 1'b0; i++) @(negedge clk);
      start = 1'b0;
      chk("mid_send_cs", CS, 1'b0);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_bus", {CS, D1, done}, 3'b110);
      chk("mid_rst_flags", response_flags, 8'hFF);
      chk("mid_rst_data", response_data, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      prev_fl = 8'hFF; prev_dt = '0;
      run_txn(8'h40, 32'h0, 8'h95, 81, 0, 80, 8'h01, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_chk + 1);
      $fatal(1, "watchdog");
   end

endmodule
